// File: rtl/in_buffer_16bit.sv
// in_buffer_16bit: particle input buffer. Accepts a stream of 16-bit words
// (PosX, PosY, Mass per particle) into N entries and serves zero-latency
// combinational reads of any field of any entry.
module in_buffer_16bit #(
  parameter int N        = 256,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic [15:0]         DATA_IN,
  input  logic                S_VALID,
  output logic                S_READY,
  input  logic                CLEAR,
  output logic                FULL,
  input  logic [IDX_BITS-1:0] RD_IDX,
  input  logic [1:0]          RD_SEL,
  output logic [15:0]         DATA_OUT
);

  typedef enum logic [1:0] {
    FLD_POSX = 2'd0,
    FLD_POSY = 2'd1,
    FLD_MASS = 2'd2
  } fld_e;

  fld_e                fld_q, fld_d;
  logic [IDX_BITS-1:0] wr_idx_q, wr_idx_d;
  logic                full_q, full_d;

  logic [15:0] posx_q [N];
  logic [15:0] posy_q [N];
  logic [15:0] mass_q [N];

  logic accept;

  // Handshake: a word is taken only when ready; CLEAR and reset both block it.
  assign accept = S_VALID && S_READY;
  assign FULL   = full_q;

  // Field counter / write index / full flag register.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      fld_q    <= FLD_POSX;
      wr_idx_q <= '0;
      full_q   <= 1'b0;
    end else begin
      fld_q    <= fld_d;
      wr_idx_q <= wr_idx_d;
      full_q   <= full_d;
    end
  end

  // Next-state: CLEAR restarts at entry 0 PosX; otherwise advance on accept.
  always_comb begin
    fld_d    = fld_q;
    wr_idx_d = wr_idx_q;
    full_d   = full_q;
    if (CLEAR) begin
      fld_d    = FLD_POSX;
      wr_idx_d = '0;
      full_d   = 1'b0;
    end else if (accept) begin
      case (fld_q)
        FLD_POSX: fld_d = FLD_POSY;
        FLD_POSY: fld_d = FLD_MASS;
        FLD_MASS: begin
          fld_d    = FLD_POSX;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == IDX_BITS'(N - 1)) begin
            full_d = 1'b1;
          end
        end
        default: fld_d = FLD_POSX;
      endcase
    end
  end

  // Outputs: ready flag and zero-latency field read (sel 3 reads as zero).
  always_comb begin
    S_READY  = !full_q && !CLEAR && !RESET_IN;
    DATA_OUT = '0;
    case (RD_SEL)
      2'd0:    DATA_OUT = posx_q[RD_IDX];
      2'd1:    DATA_OUT = posy_q[RD_IDX];
      2'd2:    DATA_OUT = mass_q[RD_IDX];
      default: DATA_OUT = '0;
    endcase
  end

  // Storage: zeroed on reset; an accepted word lands in the current field.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      for (int unsigned i = 0; i < N; i++) begin
        posx_q[i] <= '0;
        posy_q[i] <= '0;
        mass_q[i] <= '0;
      end
    end else if (accept) begin
      case (fld_q)
        FLD_POSX: posx_q[wr_idx_q] <= DATA_IN;
        FLD_POSY: posy_q[wr_idx_q] <= DATA_IN;
        FLD_MASS: mass_q[wr_idx_q] <= DATA_IN;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_in_buffer_16bit.sv
// tb_in_buffer_16bit: directed, table-driven check of in_buffer_16bit with N=4.
module tb_in_buffer_16bit;

  localparam int N  = 4;
  localparam int IB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   din;
  logic          s_valid;
  logic          s_ready;
  logic          clear;
  logic          full;
  logic [IB-1:0] rd_idx;
  logic [1:0]    rd_sel;
  logic [15:0]   dout;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [1:0]  idx;
    logic [1:0]  sel;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[$];

  in_buffer_16bit #(.N(N), .IDX_BITS(IB)) dut (
    .CLK_IN   (clk),
    .RESET_IN (rst),
    .DATA_IN  (din),
    .S_VALID  (s_valid),
    .S_READY  (s_ready),
    .CLEAR    (clear),
    .FULL     (full),
    .RD_IDX   (rd_idx),
    .RD_SEL   (rd_sel),
    .DATA_OUT (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [1:0] idx, input logic [1:0] sel, input logic [15:0] exp);
    rd_vec_t v;
    v.idx = idx; v.sel = sel; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      rd_idx = vecs[i].idx;
      rd_sel = vecs[i].sel;
      #1;
      chk($sformatf("%s rd(%0d,%0d)", tag, vecs[i].idx, vecs[i].sel), dout, vecs[i].exp);
    end
    vecs.delete();
  endtask

  task automatic rd(input string name, input logic [1:0] idx, input logic [1:0] sel,
                    input logic [15:0] exp);
    rd_idx = idx; rd_sel = sel;
    #1;
    chk(name, dout, exp);
  endtask

  // One cycle with S_VALID high; inputs change 1 time unit after the edge.
  task automatic push(input logic [15:0] w);
    din = w; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; s_valid = 1'b0; clear = 1'b0; rd_idx = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("ready in reset", 16'(s_ready), 16'd0);
    chk("full in reset", 16'(full), 16'd0);
    rst = 1'b0;
    #1;
    chk("ready after reset", 16'(s_ready), 16'd1);
    for (int i = 0; i < N; i++) for (int s = 0; s < 3; s++) add(2'(i), 2'(s), 16'h0000);
    run_vecs("reset");

    // Two particles.
    push(16'h1111); push(16'h2222); push(16'h3333);
    push(16'h4444); push(16'h5555); push(16'h6666);
    add(0, 0, 16'h1111); add(0, 1, 16'h2222); add(0, 2, 16'h3333);
    add(1, 0, 16'h4444); add(1, 1, 16'h5555); add(1, 2, 16'h6666);
    add(1, 3, 16'h0000); add(2, 0, 16'h0000);
    run_vecs("fill2");

    // Fill to N; FULL only after the 12th word.
    push(16'h7777); push(16'h8888); push(16'h9999);
    push(16'hAAAA); push(16'hBBBB);
    chk("full after 11 words", 16'(full), 16'd0);
    chk("ready after 11 words", 16'(s_ready), 16'd1);
    push(16'hCCCC);
    chk("full after 12 words", 16'(full), 16'd1);
    chk("ready when full", 16'(s_ready), 16'd0);
    add(3, 1, 16'hBBBB); add(2, 2, 16'h9999); add(3, 2, 16'hCCCC); add(3, 0, 16'hAAAA);
    run_vecs("full");

    // Writes ignored while full.
    din = 16'hDEAD; s_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("full held", 16'(full), 16'd1);
    add(0, 0, 16'h1111); add(3, 2, 16'hCCCC); add(0, 3, 16'h0000);
    run_vecs("hold");

    // One-cycle CLEAR: flags drop, data kept, refill starts at entry 0 PosX.
    clear = 1'b1;
    #1;
    chk("ready during clear", 16'(s_ready), 16'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    chk("full after clear", 16'(full), 16'd0);
    chk("ready after clear", 16'(s_ready), 16'd1);
    rd("retained (2,2)", 2, 2, 16'h9999);
    push(16'h1234);
    rd("overwrite (0,0)", 0, 0, 16'h1234);
    rd("untouched (0,1)", 0, 1, 16'h2222);

    // CLEAR mid-particle with S_VALID: nothing written, partial particle dropped.
    push(16'h5678);
    rd("second word (0,1)", 0, 1, 16'h5678);
    clear = 1'b1; s_valid = 1'b1; din = 16'hFFFF;
    @(posedge clk); #1;
    clear = 1'b0; s_valid = 1'b0;
    rd("no write on clear (0,2)", 0, 2, 16'h3333);
    push(16'hEEEE);
    add(0, 0, 16'hEEEE); add(0, 1, 16'h5678); add(0, 2, 16'h3333);
    run_vecs("clr_mid");

    // Reset mid-fill with a word presented.
    push(16'h0A0A); push(16'h0B0B); push(16'h0C0C); push(16'h0D0D);
    rst = 1'b1; s_valid = 1'b1; din = 16'hABCD;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("ready in mid reset", 16'(s_ready), 16'd0);
    rst = 1'b0;
    #1;
    chk("full after mid reset", 16'(full), 16'd0);
    chk("ready after mid reset", 16'(s_ready), 16'd1);
    for (int i = 0; i < N; i++) for (int s = 0; s < 4; s++) add(2'(i), 2'(s), 16'h0000);
    run_vecs("midreset");
    push(16'h0101);
    rd("restart (0,0)", 0, 0, 16'h0101);
    rd("restart (0,1)", 0, 1, 16'h0000);
    rd("sel3 after write", 0, 3, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/in_buffer_16bit.md
IN_BUFFER_16BIT -- requirements
Module: in_buffer_16bit

Interface
REQ-001 SHALL have parameter N, default 256, number of particle entries (power of two, >=2).
REQ-002 SHALL have parameter IDX_BITS, default $clog2(N), width of the particle index.
REQ-003 SHALL have port CLK_IN  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET_IN  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port DATA_IN  input  16  stream word (PosX, PosY or Mass).
REQ-006 SHALL have port S_VALID  input  1  upstream word valid.
REQ-007 SHALL have port S_READY  output  1  buffer can accept a word.
REQ-008 SHALL have port CLEAR  input  1  restart filling from entry 0.
REQ-009 SHALL have port FULL  output  1  all N entries written.
REQ-010 SHALL have port RD_IDX  input  IDX_BITS  particle index to read.
REQ-011 SHALL have port RD_SEL  input  2  field select: 0=PosX, 1=PosY, 2=Mass, 3=reserved.
REQ-012 SHALL have port DATA_OUT  output  16  selected field of the selected entry.

Function
REQ-013 SHALL store N entries of three 16-bit fields (PosX, PosY, Mass).
REQ-014 SHALL define the handshake as S_VALID=1 and S_READY=1 at a rising CLK_IN edge; exactly one word is accepted per such edge.
REQ-015 SHALL drive S_READY = !FULL && !CLEAR && !RESET_IN, combinationally.
REQ-016 SHALL write accepted words in stream order: field counter 0->1->2 gives PosX, PosY, Mass of the entry at the write index.
REQ-017 SHALL, on accepting a word with field counter 2, wrap the field counter to 0 and increment the write index.
REQ-018 SHALL set FULL on the edge that accepts the Mass word of entry N-1; FULL stays high until CLEAR or reset.
REQ-019 SHALL hold the write index and field counter while FULL=1; S_VALID is ignored.
REQ-020 SHALL ignore DATA_IN when S_VALID=0; the counters do not advance.
REQ-021 SHALL, when CLEAR=1 at an edge, set the write index and field counter to 0 and FULL to 0; stored data is retained.
REQ-022 SHALL give CLEAR priority over a simultaneous S_VALID; no word is written in that cycle.
REQ-023 SHALL, with CLEAR mid-particle, discard the partial particle; the next accepted word is PosX of entry 0.
REQ-024 SHALL make DATA_OUT a purely combinational read of entry RD_IDX, field RD_SEL, with zero latency.
REQ-025 SHALL drive DATA_OUT = 16'h0000 when RD_SEL=3.
REQ-026 SHALL make a word written at edge k readable on DATA_OUT immediately after edge k.
REQ-027 SHALL allow reads of any entry at any time, including during writing and while FULL=1.

Reset
REQ-028 SHALL, when RESET_IN=1 at an edge, clear the write index, field counter and FULL to 0 and all stored fields to 16'h0000.
REQ-029 SHALL make reset override CLEAR and S_VALID; a word presented during reset is not written.
REQ-030 SHALL drive S_READY=1 in the first cycle after reset is released, when CLEAR=0.
REQ-031 SHALL let reset asserted mid-particle or mid-fill abandon all progress, with the same result as REQ-028.

Verification (N=4)
REQ-032 SHALL cover: reset, then push 1111/2222/3333 and 4444/5555/6666 -> reads (0,0)=1111, (0,1)=2222, (0,2)=3333, (1,0)=4444, (1,2)=6666.
REQ-033 SHALL cover: push particles 7777/8888/9999 and AAAA/BBBB/CCCC -> FULL=1 and S_READY=0 after the 12th accepted word; (3,1)=BBBB.
REQ-034 SHALL cover: when full, hold S_VALID=1 with DATA_IN=DEAD for 3 cycles -> no counter change; (0,0) stays 1111.
REQ-035 SHALL cover: pulse CLEAR for one cycle -> FULL=0, S_READY=1; (2,2) still 9999; the next push overwrites entry 0 PosX.
REQ-036 SHALL cover: push 2 words, assert CLEAR together with S_VALID, then push EEEE -> EEEE lands in (0,0); (0,2) unchanged.
REQ-037 SHALL cover: assert RESET_IN mid-fill -> FULL=0 and all reads return 0000; RD_SEL=3 returns 0000 at any time.
